// File: rtl/fx_pkg.sv
// Shared Q16.16 fixed-point definitions for the ray-intersection datapath blocks.
package fx_pkg;

  localparam int FX_WIDTH = 32;
  localparam int FX_FRAC  = 16;

  localparam logic [FX_WIDTH-1:0] FX_MAX = 32'h7FFF_FFFF;
  localparam logic [FX_WIDTH-1:0] FX_MIN = 32'h8000_0000;

  typedef logic signed [FX_WIDTH-1:0] fx_t;

endpackage

// File: rtl/fx_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module fx_div_step #(
  parameter int MW = 33
) (
  input  logic [MW-1:0] rem_in,
  input  logic          dbit,
  input  logic [MW-1:0] divisor,
  output logic [MW-1:0] rem_out,
  output logic          qbit
);

  logic [MW:0] trial;
  logic [MW:0] diff;

  always_comb begin
    trial   = {rem_in, dbit};
    diff    = trial - {1'b0, divisor};
    qbit    = (trial >= {1'b0, divisor});
    rem_out = qbit ? diff[MW-1:0] : trial[MW-1:0];
  end

endmodule

// File: rtl/fx_div.sv
// Iterative signed Q16.16 divider: one quotient bit per clock, saturating, with divide-by-zero flag.
//   state | meaning
//   IDLE  | ready for operands
//   CALC  | restoring iteration, one quotient bit per cycle
//   FIX   | apply sign / saturation, register result
//   DONE  | result held until out_ready
module fx_div
  import fx_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH,
  parameter int FRAC  = FX_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic             div0,
  output logic             ovf
);

  localparam int QW = WIDTH + FRAC;
  localparam int MW = WIDTH + 1;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0]    CNT_START = CW'(QW - 1);
  localparam logic [WIDTH-1:0] SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [QW-1:0]    MAG_POS   = QW'(SAT_POS);
  localparam logic [QW-1:0]    MAG_NEG   = QW'(SAT_NEG);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic          sign;
  logic          num_neg;
  logic          zero_den;
  logic [MW-1:0] den_mag;
  logic [MW-1:0] rem;
  logic [QW-1:0] dividend;
  logic [QW-1:0] q;
  logic [CW-1:0] cnt;

  logic [MW-1:0] num_mag;
  logic [MW-1:0] den_mag_in;
  logic [MW-1:0] rem_next;
  logic          qbit;

  // Extra bit keeps the most negative value's magnitude representable.
  assign num_mag    = num[WIDTH-1] ? (~{1'b1, num}) + MW'(1) : {1'b0, num};
  assign den_mag_in = den[WIDTH-1] ? (~{1'b1, den}) + MW'(1) : {1'b0, den};
  assign in_ready   = (state == IDLE);

  fx_div_step #(.MW(MW)) u_step (
    .rem_in  (rem),
    .dbit    (dividend[QW-1]),
    .divisor (den_mag),
    .rem_out (rem_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      quot      <= '0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
      sign      <= 1'b0;
      num_neg   <= 1'b0;
      zero_den  <= 1'b0;
      den_mag   <= '0;
      rem       <= '0;
      dividend  <= '0;
      q         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= num[WIDTH-1] ^ den[WIDTH-1];
            num_neg  <= num[WIDTH-1];
            zero_den <= (den == '0);
            den_mag  <= den_mag_in;
            dividend <= {num_mag[WIDTH-1:0], {FRAC{1'b0}}};
            rem      <= '0;
            q        <= '0;
            cnt      <= CNT_START;
            state    <= CALC;
          end
        end
        CALC: begin
          rem      <= rem_next;
          dividend <= {dividend[QW-2:0], 1'b0};
          q        <= {q[QW-2:0], qbit};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          div0 <= zero_den;
          ovf  <= 1'b0;
          if (zero_den) begin
            quot <= num_neg ? SAT_NEG : SAT_POS;
          end else if (!sign && q > MAG_POS) begin
            quot <= SAT_POS;
            ovf  <= 1'b1;
          end else if (sign && q > MAG_NEG) begin
            quot <= SAT_NEG;
            ovf  <= 1'b1;
          end else begin
            quot <= sign ? (~q[WIDTH-1:0]) + WIDTH'(1) : q[WIDTH-1:0];
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_div.sv
// Randomized and directed check of fx_div against an integer-arithmetic reference model.
module tb_fx_div;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num;
  logic [31:0] den;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quot;
  logic        div0;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  fx_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .div0      (div0),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient of (num * 2^16) / den, truncated toward zero, then clamped.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eq, output logic e0, output logic eo);
    longint n, d, q;
    n  = longint'($signed(a));
    d  = longint'($signed(b));
    e0 = 1'b0;
    eo = 1'b0;
    if (d == 0) begin
      e0 = 1'b1;
      eq = (n >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else begin
      q = (n * 65536) / d;
      if (q > 64'sd2147483647) begin
        eq = 32'h7FFF_FFFF;
        eo = 1'b1;
      end else if (q < -64'sd2147483648) begin
        eq = 32'h8000_0000;
        eo = 1'b1;
      end else begin
        eq = q[31:0];
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_rdy", in_ready, 1);
    in_valid = 1'b1;
    num      = a;
    den      = b;
    @(negedge clk);
    in_valid = 1'b0;
    num      = $urandom;
    den      = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq;
    logic        e0, eo;
    model(a, b, eq, e0, eo);
    chk("quot", quot, eq);
    chk("div0", div0, e0);
    chk("ovf", ovf, eo);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_idle", in_ready, 1);
    chk("rel_ov", out_valid, 0);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic early);
    int lat;
    out_ready = early;
    send(a, b);
    wait_done(lat);
    chk("latency", lat, 49);
    check_result(a, b);
    release_result();
  endtask

  logic [31:0] da [10] = '{32'h0003_0000, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000,
                           32'h7FFF_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000,
                           32'hFFFE_8000, 32'h0000_0001};
  logic [31:0] db [10] = '{32'h0002_0000, 32'h0003_0000, 32'h0000_0000, 32'h0000_0000,
                           32'h0000_0001, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_0000,
                           32'h0000_8000, 32'h7FFF_FFFF};

  initial begin
    int          lat;
    logic [31:0] a, b;
    logic [31:0] hold_q;
    logic        hold_0, hold_o;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    num       = '0;
    den       = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_div0", div0, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_div(da[i], db[i], 1'b0);

    // Result held under backpressure while new operands wait at the input.
    out_ready = 1'b0;
    send(32'h0007_0000, 32'h0002_0000);
    wait_done(lat);
    chk("hold_lat", lat, 49);
    model(32'h0007_0000, 32'h0002_0000, hold_q, hold_0, hold_o);
    in_valid = 1'b1;
    num      = 32'h0005_0000;
    den      = 32'h0002_0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_quot", quot, hold_q);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_flags", {div0, ovf}, {hold_0, hold_o});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_rel_idle", in_ready, 1);
    chk("hold_rel_ov", out_valid, 0);
    @(negedge clk);
    chk("hold_accept", in_ready, 0);
    in_valid = 1'b0;
    num      = $urandom;
    den      = $urandom;
    wait_done(lat);
    chk("hold_next_lat", lat, 49);
    check_result(32'h0005_0000, 32'h0002_0000);
    release_result();

    // Reset in the middle of an iteration discards the operation.
    send(32'h0003_0000, 32'h0002_0000);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_quot", quot, 0);
    chk("mid_rst_div0", div0, 0);
    chk("mid_rst_ovf", ovf, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("mid_rst_no_result", out_valid, 0);
    end
    run_div(32'h0006_0000, 32'h0003_0000, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(0, 32'h0003_FFFF);
        2: b = -$urandom_range(1, 32'h0003_FFFF);
        default: b = (i % 2 == 0) ? 32'h0 : $urandom_range(1, 8);
      endcase
      if ($urandom_range(0, 3) == 0) a = a >>> 12;
      run_div(a, b, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
